// File: rtl/lpc_buf_pkg.sv
// lpc_buf_pkg
// Shared definitions for the LPC ping-pong sample buffer: default geometry
// (G.729 LPC window of 240 16-bit samples), the per-bank life-cycle states
// and the magnitude helper used by the optional peak tracker
// (LPC_PINGPONG_MAX_TRACK_EN).
package lpc_buf_pkg;

    localparam int LPC_DATA_W = 16;
    localparam int LPC_DEPTH  = 240;
    localparam int LPC_ADDR_W = 8;

    // Life cycle of one bank: EMPTY -> FILLING -> FULL -> READING -> EMPTY
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    // Derive a bank's state from its full flag and whether the write or
    // read pointer currently selects it.
    function automatic bank_state_t bank_state(input logic is_full,
                                               input logic is_wb,
                                               input logic is_rb);
        if (is_full)
            return is_rb ? BANK_READING : BANK_FULL;
        else
            return is_wb ? BANK_FILLING : BANK_EMPTY;
    endfunction

    // Absolute value of a sign-extended sample of the given width; the most
    // negative value saturates to the largest positive value of that width.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] value,
                                            input int width);
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (width - 1));
        if (value == most_neg)
            return (32'd1 << (width - 1)) - 32'd1;
        else if (value < 0)
            return unsigned'(-value);
        else
            return unsigned'(value);
    endfunction

endpackage

// File: rtl/lpc_buf_bank.sv
// lpc_buf_bank
// One DEPTH x DATA_W simple dual-port sample RAM.
// Ports:
//   clock, reset        system clock, async active-high reset (read reg only)
//   wr_en/wr_addr/wr_data  synchronous write port (caller guarantees range)
//   rd_addr             read address, sampled every cycle
//   rd_data             registered read data, 0 when rd_addr >= DEPTH
module lpc_buf_bank
    import lpc_buf_pkg::*;
#(
    parameter int DATA_W = LPC_DATA_W,
    parameter int DEPTH  = LPC_DEPTH,
    parameter int ADDR_W = LPC_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read register returns zero for addresses beyond the frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else if ({1'b0, rd_addr} < DEPTH_LIM)
            rd_data <= mem[rd_addr];
        else
            rd_data <= '0;
    end

endmodule

// File: rtl/lpc_pingpong_buf.sv
// lpc_pingpong_buf
// Double-buffered frame store between the Hamming window and the
// autocorrelation stage. The writer fills bank wb while the reader consumes
// the completed frame in bank rb.
// Ports:
//   clock, reset                      clock, async active-high reset
//   In_Write, In_Count, In_Sample     sample write into the write bank
//   In_Done                           frame complete pulse from the writer
//   In_Ready                          write bank is free
//   Out_Count, Out_Sample             read address, registered read data
//   Out_Valid                         read bank holds a complete frame
//   Out_Done                          reader releases the read bank
//   Err_Overrun                       sticky: writer acted while not ready
//   Out_Max                           peak |sample| of the read bank, only
//                                     when LPC_PINGPONG_MAX_TRACK_EN is defined
module lpc_pingpong_buf
    import lpc_buf_pkg::*;
#(
    parameter int DATA_W = LPC_DATA_W,
    parameter int DEPTH  = LPC_DEPTH,
    parameter int ADDR_W = LPC_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              In_Write,
    input  logic [ADDR_W-1:0] In_Count,
    input  logic [DATA_W-1:0] In_Sample,
    input  logic              In_Done,
    output logic              In_Ready,
    input  logic [ADDR_W-1:0] Out_Count,
    output logic [DATA_W-1:0] Out_Sample,
    output logic              Out_Valid,
    input  logic              Out_Done,
    output logic              Err_Overrun
`ifdef LPC_PINGPONG_MAX_TRACK_EN
    ,
    output logic [DATA_W-1:0] Out_Max
`endif
);

    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    logic        wb, rb, next_wb, next_rb;
    logic [1:0]  full, next_full;
    logic        next_err;
    logic        rd_sel;
    logic        wr_ok, wr_release, rd_release;
    logic [DATA_W-1:0] rd_data0, rd_data1;
    bank_state_t bank_st [2];

    // Per-bank life-cycle state; the handshake outputs fall out of it.
    always_comb begin
        bank_st[0] = bank_state(full[0], wb == 1'b0, rb == 1'b0);
        bank_st[1] = bank_state(full[1], wb == 1'b1, rb == 1'b1);
    end

    assign In_Ready  = (bank_st[wb] == BANK_FILLING);
    assign Out_Valid = (bank_st[rb] == BANK_READING);

    assign wr_ok      = In_Write & In_Ready & ({1'b0, In_Count} < DEPTH_LIM);
    assign wr_release = In_Done & In_Ready;
    assign rd_release = Out_Done & Out_Valid;

    // Bank control register: pointers, full flags and the overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb          <= 1'b0;
            rb          <= 1'b0;
            full        <= 2'b00;
            Err_Overrun <= 1'b0;
            rd_sel      <= 1'b0;
        end else begin
            wb          <= next_wb;
            rb          <= next_rb;
            full        <= next_full;
            Err_Overrun <= next_err;
            rd_sel      <= rb;
        end
    end

    // Next-state logic. A finished write frame is always in a different bank
    // from the frame being released, so both updates can apply together.
    always_comb begin
        next_wb   = wb;
        next_rb   = rb;
        next_full = full;
        next_err  = Err_Overrun;
        if (wr_release) begin
            next_full[wb] = 1'b1;
            next_wb       = ~wb;
        end
        if (rd_release) begin
            next_full[rb] = 1'b0;
            next_rb       = ~rb;
        end
        if ((In_Write | In_Done) & ~In_Ready)
            next_err = 1'b1;
    end

    lpc_buf_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_ok & ~wb),
        .wr_addr (In_Count),
        .wr_data (In_Sample),
        .rd_addr (Out_Count),
        .rd_data (rd_data0)
    );

    lpc_buf_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_ok & wb),
        .wr_addr (In_Count),
        .wr_data (In_Sample),
        .rd_addr (Out_Count),
        .rd_data (rd_data1)
    );

    // rd_sel remembers which bank the registered read came from.
    assign Out_Sample = rd_sel ? rd_data1 : rd_data0;

`ifdef LPC_PINGPONG_MAX_TRACK_EN
    logic [DATA_W-1:0] peak [2];
    logic [DATA_W-1:0] sample_mag;

    assign sample_mag = DATA_W'(abs_sat(32'(signed'(In_Sample)), DATA_W));

    // Peak magnitude per bank, cleared when the reader releases that bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            peak[0] <= '0;
            peak[1] <= '0;
        end else begin
            if (rd_release)
                peak[rb] <= '0;
            if (wr_ok && (sample_mag > peak[wb]))
                peak[wb] <= sample_mag;
        end
    end

    assign Out_Max = peak[rb];
`endif

endmodule

// File: tb/tb_lpc_pingpong_buf.sv
// tb_lpc_pingpong_buf
// Directed bench for lpc_pingpong_buf with default parameters
// (DATA_W=16, DEPTH=240, ADDR_W=8). Peak-tracking checks run only when
// LPC_PINGPONG_MAX_TRACK_EN is defined.
module tb_lpc_pingpong_buf;

    logic        clock = 1'b0;
    logic        reset;
    logic        In_Write;
    logic [7:0]  In_Count;
    logic [15:0] In_Sample;
    logic        In_Done;
    logic        In_Ready;
    logic [7:0]  Out_Count;
    logic [15:0] Out_Sample;
    logic        Out_Valid;
    logic        Out_Done;
    logic        Err_Overrun;
`ifdef LPC_PINGPONG_MAX_TRACK_EN
    logic [15:0] Out_Max;
`endif

    int checkCount = 0;
    int errorCount = 0;

    lpc_pingpong_buf dut (
        .clock       (clock),
        .reset       (reset),
        .In_Write    (In_Write),
        .In_Count    (In_Count),
        .In_Sample   (In_Sample),
        .In_Done     (In_Done),
        .In_Ready    (In_Ready),
        .Out_Count   (Out_Count),
        .Out_Sample  (Out_Sample),
        .Out_Valid   (Out_Valid),
        .Out_Done    (Out_Done),
        .Err_Overrun (Err_Overrun)
`ifdef LPC_PINGPONG_MAX_TRACK_EN
        ,
        .Out_Max     (Out_Max)
`endif
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one cycle of writer/reader strobes, then drop the strobes.
    task automatic applyStimulus(input logic wr, input logic [7:0] cnt,
                                 input logic [15:0] smp, input logic idone,
                                 input logic odone);
        In_Write  = wr;
        In_Count  = cnt;
        In_Sample = smp;
        In_Done   = idone;
        Out_Done  = odone;
        tick();
        In_Write  = 1'b0;
        In_Done   = 1'b0;
        Out_Done  = 1'b0;
    endtask

    // Set the read address and wait out the 1-cycle read latency.
    task automatic readAt(input logic [7:0] cnt);
        Out_Count = cnt;
        tick();
    endtask

    // Write a whole frame of base+address values, then pulse In_Done.
    task automatic writeFrame(input int base);
        for (int i = 0; i < 240; i++)
            applyStimulus(1'b1, 8'(i), 16'(base + i), 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        In_Write = 1'b0; In_Count = '0; In_Sample = '0; In_Done = 1'b0;
        Out_Count = '0; Out_Done = 1'b0;
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("rst_in_ready", 32'(In_Ready), 32'd1);
        checkOutput("rst_out_sample", 32'(Out_Sample), 32'd0);
        checkOutput("rst_overrun", 32'(Err_Overrun), 32'd0);
        reset = 1'b0;
        tick();

        // Frame A (value = address) into bank 0
        writeFrame(0);
        checkOutput("a_out_valid", 32'(Out_Valid), 32'd1);
        checkOutput("a_in_ready", 32'(In_Ready), 32'd1);
        readAt(8'd17);
        checkOutput("a_read17", 32'(Out_Sample), 32'd17);
        readAt(8'd239);
        checkOutput("a_read239", 32'(Out_Sample), 32'd239);
        readAt(8'd240);
        checkOutput("read240_zero", 32'(Out_Sample), 32'd0);
        readAt(8'd255);
        checkOutput("read255_zero", 32'(Out_Sample), 32'd0);

        // Out-of-range write while ready: dropped, no overrun
        applyStimulus(1'b1, 8'd250, 16'd9999, 1'b0, 1'b0);
        checkOutput("oor_write_no_err", 32'(Err_Overrun), 32'd0);

        // Frame B (1000 + address) into bank 1 -> both banks full
        writeFrame(1000);
        checkOutput("both_full_in_ready", 32'(In_Ready), 32'd0);
        checkOutput("both_full_valid", 32'(Out_Valid), 32'd1);

        // Writer misbehaves while not ready
        applyStimulus(1'b1, 8'd5, 16'd7777, 1'b0, 1'b0);
        checkOutput("overrun_write", 32'(Err_Overrun), 32'd1);
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
        checkOutput("overrun_done_ignored", 32'(In_Ready), 32'd0);
        readAt(8'd5);
        checkOutput("a_unchanged5", 32'(Out_Sample), 32'd5);

        // Release frame A -> bank 0 free, reader moves to frame B
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
        checkOutput("release_in_ready", 32'(In_Ready), 32'd1);
        checkOutput("release_valid", 32'(Out_Valid), 32'd1);
        readAt(8'd5);
        checkOutput("b_unchanged5", 32'(Out_Sample), 32'd1005);
        checkOutput("overrun_sticky", 32'(Err_Overrun), 32'd1);

        // Frame C into bank 0; last sample written in the same cycle as
        // In_Done and Out_Done (release of B)
        for (int i = 0; i < 239; i++)
            applyStimulus(1'b1, 8'(i), 16'(2000 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd239, 16'd4242, 1'b1, 1'b1);
        checkOutput("swap_in_ready", 32'(In_Ready), 32'd1);
        checkOutput("swap_valid", 32'(Out_Valid), 32'd1);
        readAt(8'd5);
        checkOutput("c_read5", 32'(Out_Sample), 32'd2005);
        readAt(8'd239);
        checkOutput("c_last_write", 32'(Out_Sample), 32'd4242);

        // Partial frame into bank 1, then asynchronous reset mid-frame
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b1, 8'(i), 16'(3000 + i), 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(Out_Valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(In_Ready), 32'd1);
        checkOutput("mid_rst_sample", 32'(Out_Sample), 32'd0);
        checkOutput("mid_rst_overrun", 32'(Err_Overrun), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // First write after reset must land in bank 0 (old bank0[3]=2003,
        // bank1[3]=3003)
        applyStimulus(1'b1, 8'd3, 16'd555, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
        checkOutput("post_rst_valid", 32'(Out_Valid), 32'd1);
        readAt(8'd3);
        checkOutput("post_rst_wb0", 32'(Out_Sample), 32'd555);

`ifdef LPC_PINGPONG_MAX_TRACK_EN
        // Release bank 0 (rb -> 1); peak frame into bank 1
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd0, 16'h8000, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd1, 16'd1000, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd2, 16'hFFFB, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
        checkOutput("max_saturate", 32'(Out_Max), 32'd32767);
        // Frame 3, -9, 4 into bank 0, then release bank 1
        applyStimulus(1'b1, 8'd0, 16'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd1, 16'hFFF7, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd2, 16'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
        checkOutput("max_after_swap", 32'(Out_Max), 32'd9);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
